seq_multiplier: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/mult_step.sv | 22 ++
 rtl/seq_multiplier.sv | 101 ++++++++++
 tb/tb_seq_multiplier.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier state encodings, default operand width
// and the iteration counter width helper.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    localparam int DEFAULT_WIDTH = 32;

    // Guard WIDTH=1 so the counter never collapses to zero bits.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into the
// upper half of the accumulator, keep the carry, and shift right by one.
module mult_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0]   m,
    output logic [2*WIDTH-1:0] p_out
);

    logic [WIDTH:0] sum;

    // The carry lands in the top bit after the shift, so it must not be lost.
    always_comb begin
        sum = {1'b0, p_in[2*WIDTH-1:WIDTH]};
        if (p_in[0]) begin
            sum = {1'b0, p_in[2*WIDTH-1:WIDTH]} + {1'b0, m};
        end
        p_out = {sum, p_in[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier: WIDTH iterations per product,
// one-cycle done pulse, result held until the next completion.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_e          state_q, state_d;
    logic [2*WIDTH-1:0]   p_q, p_d, p_next;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;

    mult_step #(.WIDTH(WIDTH)) u_step (
        .p_in  (p_q),
        .m     (m_q),
        .p_out (p_next)
    );

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept = start;
            end
            ST_CALC: begin
                p_d   = p_next;
                cnt_d = cnt_q + 1'b1;
                // The product takes the post-shift value of the last step.
                if (cnt_q == LAST_CNT) begin
                    state_d   = ST_DONE;
                    product_d = p_next;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                accept  = start;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d = ST_CALC;
            m_d     = a;
            p_d     = {{WIDTH{1'b0}}, b};
            cnt_d   = '0;
        end

        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            p_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed vector table, random
// operands against an arithmetic reference, and multi-cycle corner cases.
module tb_seq_multiplier;

    localparam int W       = 32;
    localparam int LATENCY = W + 1;
    localparam int BOUND   = 100;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] expected;
    } vec_t;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks;
    int failures;
    logic [2*W-1:0] last_result;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y);
        return 64'(x) * 64'(y);
    endfunction

    task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                               input logic [2*W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a start in the current cycle and follows the run to its done cycle.
    task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                 input logic [2*W-1:0] expected, input string name);
        int  n;
        bit  held;
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        checkOutput({name, " busy after accept"}, 64'(busy), 64'd1);
        n    = 0;
        held = 1'b1;
        while (!done && n < BOUND) begin
            if (product !== last_result) held = 1'b0;
            tick();
            n++;
        end
        checkOutput({name, " latency"}, 64'(n + 1), 64'(LATENCY));
        checkOutput({name, " product held during calc"}, 64'(held), 64'd1);
        checkOutput({name, " product"}, product, expected);
        checkOutput({name, " busy in done cycle"}, 64'(busy), 64'd0);
        last_result = expected;
    endtask

    initial begin
        vec_t vecs[5];
        logic [W-1:0] ra, rb, a0, b0;
        int n;
        int done_count;

        checks      = 0;
        failures    = 0;
        last_result = '0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{32'd3,        32'd5,        64'd15};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[2] = '{32'd0,        32'hDEADBEEF, 64'd0};
        vecs[3] = '{32'h12345678, 32'd1,        64'h0000000012345678};
        vecs[4] = '{32'h00010000, 32'h00010000, 64'h0000000100000000};

        tick();
        tick();
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset product", product, 64'd0);

        // Reset and start together: reset must win.
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
        tick();
        checkOutput("reset beats start busy", 64'(busy), 64'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        // Table runs are issued back-to-back from each done cycle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].expected, $sformatf("vec%0d", i));
        end
        tick();
        checkOutput("done single cycle", 64'(done), 64'd0);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'hFFFFFFFF : W'($urandom);
            applyStimulus(ra, rb, ref_mult(ra, rb), $sformatf("rand%0d", i));
            if (i % 2 == 0) tick();
        end

        // Start held for 5 cycles with operands changing after accept.
        tick();
        a0 = 32'hCAFEF00D;
        b0 = 32'h0BADBEEF;
        start = 1'b1;
        a     = a0;
        b     = b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            a = $urandom;
            b = $urandom;
        end
        start = 1'b0;
        n = 5;
        done_count = 0;
        while (n < LATENCY + 10) begin
            if (done) done_count++;
            tick();
            n++;
        end
        checkOutput("busy start ignored done count", 64'(done_count), 64'd1);
        checkOutput("busy start product", product, ref_mult(a0, b0));
        last_result = ref_mult(a0, b0);

        // Start held continuously: one done every LATENCY cycles.
        a0 = 32'h00000101;
        b0 = 32'h00FF00FF;
        a  = a0;
        b  = b0;
        start = 1'b1;
        n = 0;
        while (!done && n < BOUND) begin
            tick();
            n++;
        end
        checkOutput("continuous first done", 64'(done), 64'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            n = 1;
            while (!done && n < BOUND) begin
                tick();
                n++;
            end
            checkOutput($sformatf("continuous interval%0d", k), 64'(n), 64'(LATENCY));
            checkOutput($sformatf("continuous product%0d", k), product, ref_mult(a0, b0));
        end
        start = 1'b0;
        tick();
        last_result = ref_mult(a0, b0);

        // Reset ten cycles into a calculation.
        start = 1'b1;
        a = 32'h89ABCDEF;
        b = 32'h76543210;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset product", product, 64'd0);
        done_count = 0;
        for (int i = 0; i < LATENCY + 5; i++) begin
            if (done) done_count++;
            tick();
        end
        checkOutput("mid reset no done", 64'(done_count), 64'd0);
        last_result = '0;
        applyStimulus(32'd7, 32'd6, 64'd42, "after reset 7x6");

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
